// File: rtl/servo_loop_sequencer.sv
// servo_loop_sequencer
//   Runs one servo control iteration per sample period. Each iteration does an ADC capture, then
//   a PID request, then a saturated duty update for the PWM generator. Both handshakes are
//   supervised by a watchdog. The block flags overruns (a sample tick arriving while busy) and
//   handshake timeouts. Both flags are sticky.
//
// Ports
//   Clock_Nexys         rising-edge clock
//   Reset               synchronous, active-low reset
//   enable              allows sample ticks and therefore new iterations
//   Entrada_referencia  position reference, latched together with the ADC sample
//   adc_start           capture request level, held until adc_done or timeout
//   adc_done/adc_data   capture-complete pulse; data is valid with the pulse
//   pid_start           one-cycle PID start pulse
//   pid_ref/pid_meas    operands latched for the PID datapath
//   pid_done/pid_out    PID-complete pulse; signed 18-bit result is valid with the pulse
//   duty/duty_load      12-bit PWM duty; load pulse marks the cycle it is valid
//   busy                high whenever the sequencer is not idle
//   overrun             sticky: a sample tick was dropped because an iteration was running
//   timeout_err         sticky: a handshake timed out
//   clear_err           clears both sticky flags (a same-cycle new event wins)
module servo_loop_sequencer #(
  parameter int unsigned SAMPLE_DIV = 25000,
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned SHIFT      = 5
) (
  input  logic        Clock_Nexys,
  input  logic        Reset,
  input  logic        enable,
  input  logic [11:0] Entrada_referencia,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic        pid_start,
  output logic [11:0] pid_ref,
  output logic [11:0] pid_meas,
  input  logic        pid_done,
  input  logic [17:0] pid_out,
  output logic [11:0] duty,
  output logic        duty_load,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        clear_err
);

  localparam int unsigned CntW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StAdcWait,
    StPidReq,
    StPidWait,
    StUpdate
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;
  logic [11:0]       pid_ref_q, pid_ref_d;
  logic [11:0]       pid_meas_q, pid_meas_d;
  logic [11:0]       duty_q, duty_d;
  logic              adc_start_q, pid_start_q, duty_load_q, busy_q;
  logic              overrun_q, overrun_d;
  logic              timeout_err_q, timeout_err_d;
  logic              tick;
  logic              wdog_expire;
  logic              ovr_set, tmo_set;

  logic signed [17:0] pid_shifted;
  logic signed [18:0] duty_sum;
  logic [11:0]        duty_sat;

  // Sample tick generator: held at zero while disabled so a re-enable starts a full period.
  assign tick = enable && (cnt_q == CntW'(SAMPLE_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Duty conversion: centre offset plus scaled PID output, clamped to the 12-bit range.
  always_comb begin
    pid_shifted = $signed(pid_out) >>> SHIFT;
    duty_sum    = $signed({pid_shifted[17], pid_shifted}) + 19'sd2048;
    if (duty_sum[18]) begin
      duty_sat = 12'd0;
    end else if (duty_sum > 19'sd4095) begin
      duty_sat = 12'd4095;
    end else begin
      duty_sat = duty_sum[11:0];
    end
  end

  // The watchdog reaches TIMEOUT on this cycle's increment, so a wait lasts TIMEOUT cycles.
  assign wdog_expire = (wdog_q == WdogW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    pid_ref_d  = pid_ref_q;
    pid_meas_d = pid_meas_q;
    duty_d     = duty_q;
    tmo_set    = 1'b0;
    case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StAdcWait;
          wdog_d  = '0;
        end
      end
      StAdcWait: begin
        // A done pulse takes priority over a coincident timeout.
        if (adc_done) begin
          pid_meas_d = adc_data;
          pid_ref_d  = Entrada_referencia;
          state_d    = StPidReq;
        end else if (wdog_expire) begin
          tmo_set = 1'b1;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StPidReq: begin
        state_d = StPidWait;
        wdog_d  = '0;
      end
      StPidWait: begin
        if (pid_done) begin
          duty_d  = duty_sat;
          state_d = StUpdate;
        end else if (wdog_expire) begin
          tmo_set = 1'b1;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StUpdate: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ovr_set       = tick && (state_q != StIdle);
    overrun_d     = ovr_set | (overrun_q & ~clear_err);
    timeout_err_d = tmo_set | (timeout_err_q & ~clear_err);
  end

  always_ff @(posedge Clock_Nexys) begin
    if (!Reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      wdog_q        <= '0;
      pid_ref_q     <= '0;
      pid_meas_q    <= '0;
      duty_q        <= 12'd2048;
      adc_start_q   <= 1'b0;
      pid_start_q   <= 1'b0;
      duty_load_q   <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wdog_q        <= wdog_d;
      pid_ref_q     <= pid_ref_d;
      pid_meas_q    <= pid_meas_d;
      duty_q        <= duty_d;
      // Outputs are registered from the next state so they line up with the state register.
      adc_start_q   <= (state_d == StAdcWait);
      pid_start_q   <= (state_d == StPidReq);
      duty_load_q   <= (state_d == StUpdate);
      busy_q        <= (state_d != StIdle);
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign adc_start   = adc_start_q;
  assign pid_start   = pid_start_q;
  assign pid_ref     = pid_ref_q;
  assign pid_meas    = pid_meas_q;
  assign duty        = duty_q;
  assign duty_load   = duty_load_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_servo_loop_sequencer.sv
// Directed bench for servo_loop_sequencer. Expected duty values are pushed into a queue as each
// pid_done is driven and popped by a monitor on every duty_load pulse.
module tb_servo_loop_sequencer;

  localparam int unsigned SampleDiv = 64;
  localparam int unsigned Timeout   = 100;

  logic        Clock_Nexys = 1'b0;
  logic        Reset = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] Entrada_referencia = '0;
  logic        adc_start;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic        pid_start;
  logic [11:0] pid_ref, pid_meas;
  logic        pid_done = 1'b0;
  logic [17:0] pid_out = '0;
  logic [11:0] duty;
  logic        duty_load, busy, overrun, timeout_err;
  logic        clear_err = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  servo_loop_sequencer #(
    .SAMPLE_DIV(SampleDiv),
    .TIMEOUT   (Timeout),
    .SHIFT     (5)
  ) dut (
    .Clock_Nexys       (Clock_Nexys),
    .Reset             (Reset),
    .enable            (enable),
    .Entrada_referencia(Entrada_referencia),
    .adc_start         (adc_start),
    .adc_done          (adc_done),
    .adc_data          (adc_data),
    .pid_start         (pid_start),
    .pid_ref           (pid_ref),
    .pid_meas          (pid_meas),
    .pid_done          (pid_done),
    .pid_out           (pid_out),
    .duty              (duty),
    .duty_load         (duty_load),
    .busy              (busy),
    .overrun           (overrun),
    .timeout_err       (timeout_err),
    .clear_err         (clear_err)
  );

  always #5 Clock_Nexys = ~Clock_Nexys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Floor division by 2**5, offset by the centre value, then clamped.
  function automatic logic [11:0] model_duty(input int p);
    int sh, s;
    sh = (p >= 0) ? p / 32 : -((-p + 31) / 32);
    s  = 2048 + sh;
    if (s < 0) return 12'd0;
    if (s > 4095) return 12'd4095;
    return s[11:0];
  endfunction

  task automatic step();
    @(posedge Clock_Nexys);
    #1;
  endtask

  task automatic wait_adc();
    int n = 0;
    while (adc_start !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("adc_start_seen", {31'd0, adc_start}, 1);
  endtask

  // One full iteration; latencies count cycles from the start pulse to the done pulse.
  task automatic do_iter(input logic [11:0] refv, input logic [11:0] meas, input int adc_lat,
                         input int pout, input int pid_lat);
    Entrada_referencia = refv;
    wait_adc();
    repeat (adc_lat - 1) step();
    adc_done = 1'b1;
    adc_data = meas;
    step();
    adc_done = 1'b0;
    check("adc_start_dropped", {31'd0, adc_start}, 0);
    check("pid_start_pulse", {31'd0, pid_start}, 1);
    check("pid_meas", {20'd0, pid_meas}, {20'd0, meas});
    check("pid_ref", {20'd0, pid_ref}, {20'd0, refv});
    step();
    check("pid_start_single", {31'd0, pid_start}, 0);
    repeat (pid_lat - 2) step();
    pid_done = 1'b1;
    pid_out  = 18'(pout);
    exp_q.push_back(model_duty(pout));
    step();
    pid_done = 1'b0;
    step();
    check("busy_after_update", {31'd0, busy}, 0);
  endtask

  always @(negedge Clock_Nexys) begin
    if (duty_load === 1'b1) begin
      check("duty_load_expected", {31'd0, exp_q.size() > 0}, 1);
      if (exp_q.size() > 0) check("duty", {20'd0, duty}, {20'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int n;
    // Reset values
    repeat (3) step();
    check("rst_adc_start", {31'd0, adc_start}, 0);
    check("rst_pid_start", {31'd0, pid_start}, 0);
    check("rst_duty_load", {31'd0, duty_load}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    check("rst_timeout", {31'd0, timeout_err}, 0);
    check("rst_pid_ref", {20'd0, pid_ref}, 0);
    check("rst_pid_meas", {20'd0, pid_meas}, 0);
    check("rst_duty", {20'd0, duty}, 2048);

    // Tick period: first adc_start comes SAMPLE_DIV cycles after enable
    Reset  = 1'b1;
    enable = 1'b1;
    n = 0;
    while (adc_start !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("tick_period", n, SampleDiv);

    // Nominal iteration
    do_iter(12'h800, 12'h700, 20, 3200, 10);
    check("nom_overrun", {31'd0, overrun}, 0);
    check("nom_timeout", {31'd0, timeout_err}, 0);

    // Saturation, ending on the positive clamp
    do_iter(12'h800, 12'h800, 5, 0, 5);
    do_iter(12'h800, 12'h800, 5, -131072, 5);
    do_iter(12'h800, 12'h800, 5, 100000, 5);

    // ADC timeout: the sample tick during the long wait also raises overrun
    wait_adc();
    n = 0;
    while (adc_start === 1'b1 && n < 300) begin
      step();
      n++;
    end
    check("adc_hold_cycles", n, Timeout);
    check("tmo_flag", {31'd0, timeout_err}, 1);
    check("tmo_idle", {31'd0, busy}, 0);
    check("tmo_duty_kept", {20'd0, duty}, 4095);
    check("tmo_overrun", {31'd0, overrun}, 1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("clr_timeout", {31'd0, timeout_err}, 0);
    check("clr_overrun", {31'd0, overrun}, 0);
    do_iter(12'h900, 12'h880, 6, -3200, 7);
    check("post_tmo_flag", {31'd0, timeout_err}, 0);

    // Overrun: PID takes longer than the sample period
    do_iter(12'h800, 12'h7f0, 5, 6400, 80);
    check("ovr_flag", {31'd0, overrun}, 1);
    check("ovr_no_timeout", {31'd0, timeout_err}, 0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 0);

    // Reset during PID_WAIT
    wait_adc();
    repeat (2) step();
    adc_done = 1'b1;
    adc_data = 12'h123;
    step();
    adc_done = 1'b0;
    step();
    check("pre_rst_busy", {31'd0, busy}, 1);
    Reset = 1'b0;
    step();
    check("mid_rst_adc_start", {31'd0, adc_start}, 0);
    check("mid_rst_pid_start", {31'd0, pid_start}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_duty", {20'd0, duty}, 2048);
    check("mid_rst_pid_meas", {20'd0, pid_meas}, 0);
    check("mid_rst_pid_ref", {20'd0, pid_ref}, 0);
    check("mid_rst_duty_load", {31'd0, duty_load}, 0);
    Reset = 1'b1;

    // enable dropped during ADC_WAIT: iteration completes, no further captures
    wait_adc();
    enable = 1'b0;
    do_iter(12'h400, 12'h3ff, 4, -6400, 4);
    n = 0;
    repeat (150) begin
      step();
      if (adc_start === 1'b1) n++;
    end
    check("no_adc_after_disable", n, 0);

    // Stray pid_done in IDLE
    pid_done = 1'b1;
    pid_out  = 18'(64000);
    step();
    pid_done = 1'b0;
    check("stray_pid_busy", {31'd0, busy}, 0);
    step();
    check("stray_pid_load", {31'd0, duty_load}, 0);
    check("stray_pid_duty", {20'd0, duty}, 1848);

    // Stray adc_done in PID_WAIT
    enable = 1'b1;
    wait_adc();
    enable = 1'b0;
    repeat (2) step();
    adc_done = 1'b1;
    adc_data = 12'h111;
    step();
    adc_done = 1'b0;
    step();
    adc_done = 1'b1;
    adc_data = 12'h222;
    step();
    adc_done = 1'b0;
    check("stray_adc_meas", {20'd0, pid_meas}, 12'h111);
    check("stray_adc_busy", {31'd0, busy}, 1);
    check("stray_adc_start", {31'd0, adc_start}, 0);
    check("stray_adc_pid_start", {31'd0, pid_start}, 0);
    pid_done = 1'b1;
    pid_out  = 18'(320);
    exp_q.push_back(model_duty(320));
    step();
    pid_done = 1'b0;
    repeat (2) step();
    check("final_busy", {31'd0, busy}, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
